// File: rtl/mem_wb_stage.sv
// Memory access and M->W pipeline register stage.
// Latency: 1 cycle into W after the access completes (ack, misalign or timeout).
// Backpressure: StallM holds upstream while a bus request waits for mem_ack.
module mem_wb_stage #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ValidM,
  input  logic        PCSrcM,
  input  logic        RegWriteM,
  input  logic        MemtoRegM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [3:0]  WriteAddrM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        StallM,
  output logic        RegWriteW,
  output logic        PCSrcW,
  output logic [3:0]  WriteAddrW,
  output logic [31:0] ResultW,
  output logic        MemFaultW
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   wcnt_q, wcnt_d;

  logic               reg_write_w_q, reg_write_w_d;
  logic               pc_src_w_q, pc_src_w_d;
  logic [3:0]         write_addr_w_q, write_addr_w_d;
  logic [31:0]        alu_result_w_q, alu_result_w_d;
  logic [31:0]        read_data_w_q, read_data_w_d;
  logic               memto_reg_w_q, memto_reg_w_d;
  logic               mem_fault_w_q, mem_fault_w_d;

  logic               memop;
  logic               misal;
  logic               access;
  logic               timeout_hit;
  logic               abort;
  logic               stall_raw;
  logic               fault;

  // Classify the M-stage instruction and decide whether the bus is being waited on.
  always_comb begin
    memop       = ValidM & (MemtoRegM | MemWriteM);
    misal       = memop & (ALUResultM[1:0] != 2'b00);
    access      = memop & ~misal;
    timeout_hit = (state_q == WAIT) && (wcnt_q == CNT_W'(TIMEOUT_CYCLES));
    // ack in the timeout cycle still completes the access
    abort       = access & timeout_hit & ~mem_ack;
    stall_raw   = access & ~mem_ack & ~abort;
    fault       = misal | abort;
  end

  // Bus and stall outputs; both request and stall are silenced while reset is held.
  always_comb begin
    mem_we    = MemWriteM;
    mem_addr  = {ALUResultM[31:2], 2'b00};
    mem_wdata = WriteDataM;
    mem_req   = reset & access & ~abort;
    StallM    = reset & stall_raw;
  end

  // Next W contents and FSM next state.
  always_comb begin
    state_d        = state_q;
    wcnt_d         = wcnt_q;
    write_addr_w_d = WriteAddrM;
    alu_result_w_d = ALUResultM;
    memto_reg_w_d  = ValidM & MemtoRegM;
    read_data_w_d  = read_data_w_q;
    reg_write_w_d  = ValidM & RegWriteM & ~fault;
    pc_src_w_d     = ValidM & PCSrcM & ~fault;
    mem_fault_w_d  = fault;

    // while stalled the instruction stays in M, so W receives a bubble
    if (stall_raw) begin
      reg_write_w_d = 1'b0;
      pc_src_w_d    = 1'b0;
      mem_fault_w_d = 1'b0;
    end

    if (access && mem_ack) begin
      read_data_w_d = mem_rdata;
    end

    unique case (state_q)
      IDLE: begin
        if (stall_raw) begin
          state_d = WAIT;
          wcnt_d  = CNT_W'(1);
        end
      end
      WAIT: begin
        if (stall_raw) begin
          wcnt_d = wcnt_q + CNT_W'(1);
        end else begin
          // ack, abort, or the access vanished upstream
          state_d = IDLE;
          wcnt_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        wcnt_d  = '0;
      end
    endcase
  end

  // State and W pipeline register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= IDLE;
      wcnt_q         <= '0;
      reg_write_w_q  <= 1'b0;
      pc_src_w_q     <= 1'b0;
      write_addr_w_q <= '0;
      alu_result_w_q <= '0;
      read_data_w_q  <= '0;
      memto_reg_w_q  <= 1'b0;
      mem_fault_w_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      wcnt_q         <= wcnt_d;
      reg_write_w_q  <= reg_write_w_d;
      pc_src_w_q     <= pc_src_w_d;
      write_addr_w_q <= write_addr_w_d;
      alu_result_w_q <= alu_result_w_d;
      read_data_w_q  <= read_data_w_d;
      memto_reg_w_q  <= memto_reg_w_d;
      mem_fault_w_q  <= mem_fault_w_d;
    end
  end

  // Writeback result is a plain mux over the W registers.
  always_comb begin
    RegWriteW  = reg_write_w_q;
    PCSrcW     = pc_src_w_q;
    WriteAddrW = write_addr_w_q;
    MemFaultW  = mem_fault_w_q;
    ResultW    = memto_reg_w_q ? read_data_w_q : alu_result_w_q;
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: drives M-stage instructions with a
// scripted ack delay, predicts bus/stall per cycle and the retired W record.
module tb_mem_wb_stage;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        ValidM, PCSrcM, RegWriteM, MemtoRegM, MemWriteM;
  logic [31:0] ALUResultM, WriteDataM;
  logic [3:0]  WriteAddrM;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        StallM, RegWriteW, PCSrcW, MemFaultW;
  logic [3:0]  WriteAddrW;
  logic [31:0] ResultW;

  typedef struct {
    logic        rw;
    logic        pc;
    logic [3:0]  wa;
    logic [31:0] res;
    logic        flt;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  mem_wb_stage #(.TIMEOUT_CYCLES(TMO), .CNT_W(5)) dut (
    .clk(clk), .reset(reset),
    .ValidM(ValidM), .PCSrcM(PCSrcM), .RegWriteM(RegWriteM),
    .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .WriteAddrM(WriteAddrM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .StallM(StallM), .RegWriteW(RegWriteW), .PCSrcW(PCSrcW),
    .WriteAddrW(WriteAddrW), .ResultW(ResultW), .MemFaultW(MemFaultW)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive one instruction from a negedge; ack_dly = cycle index of ack (-1 = never).
  // Returns at the following negedge with the instruction retired into W.
  task automatic issue(input logic v, input logic pc, input logic rw, input logic m2r,
                       input logic mw, input logic [31:0] alu, input logic [31:0] wd,
                       input logic [3:0] wa, input logic [31:0] rdata, input int ack_dly);
    logic memop, mis, acc, tmo;
    int   fin;
    exp_t e, got;
    memop = v & (m2r | mw);
    mis   = memop & (alu[1:0] != 2'b00);
    acc   = memop & ~mis;
    tmo   = acc & ((ack_dly < 0) || (ack_dly > TMO));
    fin   = !acc ? 0 : (tmo ? TMO : ack_dly);
    e.flt = mis | tmo;
    e.rw  = v & rw & ~e.flt;
    e.pc  = v & pc & ~e.flt;
    e.wa  = wa;
    e.res = (v & m2r) ? rdata : alu;
    sb_q.push_back(e);

    ValidM = v; PCSrcM = pc; RegWriteM = rw; MemtoRegM = m2r; MemWriteM = mw;
    ALUResultM = alu; WriteDataM = wd; WriteAddrM = wa; mem_rdata = rdata;
    for (int k = 0; k <= fin; k++) begin
      mem_ack = acc && (k == ack_dly);
      #1;
      chk("stall", StallM, (k < fin) ? 1 : 0);
      chk("req", mem_req, (acc && (k < fin || !tmo)) ? 1 : 0);
      if (acc) begin
        chk("addr", mem_addr, {alu[31:2], 2'b00});
        chk("we", mem_we, mw);
        chk("wdata", mem_wdata, wd);
      end
      @(posedge clk);
      #1;
      if (k < fin) begin
        chk("bubble_rw", RegWriteW, 0);
        chk("bubble_pc", PCSrcW, 0);
        chk("bubble_flt", MemFaultW, 0);
      end else begin
        got = sb_q.pop_front();
        chk("w_rw", RegWriteW, got.rw);
        chk("w_pc", PCSrcW, got.pc);
        chk("w_wa", WriteAddrW, got.wa);
        chk("w_flt", MemFaultW, got.flt);
        if (!got.flt) chk("w_res", ResultW, got.res);
      end
      @(negedge clk);
    end
    mem_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset with a load presented: bus and stall must stay quiet
    reset = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
    ValidM = 1'b1; PCSrcM = 1'b1; RegWriteM = 1'b1; MemtoRegM = 1'b1; MemWriteM = 1'b0;
    ALUResultM = 32'h40; WriteDataM = 32'h0; WriteAddrM = 4'd7;
    @(negedge clk);
    #1;
    chk("rst_req", mem_req, 0);
    chk("rst_stall", StallM, 0);
    @(posedge clk); #1;
    chk("rst_rw", RegWriteW, 0);
    chk("rst_pc", PCSrcW, 0);
    chk("rst_wa", WriteAddrW, 0);
    chk("rst_res", ResultW, 0);
    chk("rst_flt", MemFaultW, 0);
    @(negedge clk);
    reset = 1'b1;

    //     v  pc rw m2r mw alu            wd            wa    rdata         ack
    issue(1, 0, 1, 0, 0, 32'h0000_1234, 32'h0,        4'd3, 32'h0,        -1); // ALU op
    issue(1, 0, 1, 1, 0, 32'h0000_0100, 32'h0,        4'd5, 32'hDEADBEEF, 0);  // zero-wait load
    issue(1, 0, 0, 0, 1, 32'h0000_0200, 32'hA5A5A5A5, 4'd0, 32'h0,        3);  // 3-wait store
    issue(1, 0, 1, 1, 0, 32'h0000_0102, 32'h0,        4'd6, 32'h0,        0);  // misaligned load
    issue(1, 0, 1, 0, 0, 32'h0000_0055, 32'h0,        4'd2, 32'h0,        -1); // fault pulse ends
    issue(1, 0, 1, 1, 0, 32'h0000_0300, 32'h0,        4'd9, 32'h1111_2222, -1); // timeout
    issue(1, 0, 1, 1, 0, 32'h0000_0304, 32'h0,        4'd4, 32'h3333_4444, TMO); // ack at limit
    issue(0, 1, 1, 1, 0, 32'h0000_0400, 32'h0,        4'd1, 32'h0,        0);  // bubble
    issue(1, 1, 0, 0, 0, 32'h0000_0800, 32'h0,        4'd0, 32'h0,        -1); // branch
    issue(1, 1, 1, 0, 1, 32'h0000_0203, 32'h77,       4'd8, 32'h0,        0);  // misaligned store
    for (int i = 0; i < 8; i++) begin
      issue(1, 0, 1, 1, 0, $urandom() & 32'hFFFF_FFFC, 32'h0, 4'($urandom_range(0, 15)),
            $urandom(), $urandom_range(0, 5));
    end

    // reset during the second wait cycle abandons the access
    ValidM = 1'b1; PCSrcM = 1'b0; RegWriteM = 1'b1; MemtoRegM = 1'b1; MemWriteM = 1'b0;
    ALUResultM = 32'h500; WriteAddrM = 4'd10; mem_ack = 1'b0; mem_rdata = 32'hCAFE0000;
    #1; chk("mw_stall0", StallM, 1);
    @(negedge clk);
    #1; chk("mw_stall1", StallM, 1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mw_rst_req", mem_req, 0);
    chk("mw_rst_stall", StallM, 0);
    @(posedge clk); #1;
    chk("mw_rw", RegWriteW, 0);
    chk("mw_res", ResultW, 0);
    @(negedge clk);
    reset = 1'b1; ValidM = 1'b0;
    #1;
    chk("mw_req_after", mem_req, 0);
    chk("mw_stall_after", StallM, 0);
    @(negedge clk);
    issue(1, 0, 1, 1, 0, 32'h0000_0600, 32'h0, 4'd11, 32'hBEEF_F00D, 0);

    chk("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
